// File: rtl/uart_rx_frame_collector_pkg.sv
// Shared definitions for the UART receive frame collector: byte width,
// default frame depth and the collector state encoding.
package uart_rx_frame_collector_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

endpackage

// File: rtl/uart_rx_frame_collector_frame_buffer.sv
// DEPTH x DATA_W byte store: one write port indexed by the fill count and
// one asynchronous read port indexed by the drain pointer.
module uart_rx_frame_collector_frame_buffer
    import uart_rx_frame_collector_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    // Payload storage carries no reset; contents are only read below count.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_frame_collector.sv
// Gathers UART bytes into a frame, closes it on idle timeout or full buffer,
// and drains it as a valid/ready byte stream with a last marker.
module uart_rx_frame_collector
    import uart_rx_frame_collector_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              timer_expired,
    output logic              timer_en,
    output logic              timer_clr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [LEN_W-1:0]  frame_len,
    output logic              overflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] FULL_CNT = LEN_W'(DEPTH);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] w_count_nxt;
    logic [LEN_W-1:0] r_rd_ptr;
    logic [LEN_W-1:0] w_rd_ptr_nxt;
    logic             r_timer_clr;
    logic             w_timer_clr_nxt;
    logic             r_overflow;
    logic             w_overflow_nxt;
    logic             w_wr_en;
    logic             w_last;
    logic [LEN_W-1:0] w_count_inc;
    logic [DATA_W-1:0] w_rd_data;

    uart_rx_frame_collector_frame_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_frame_buffer (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_count[ADDR_W-1:0]),
        .i_wr_data (rx_data),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign w_count_inc = r_count + LEN_W'(1);
    assign w_last      = (r_state == ST_DRAIN) && (r_rd_ptr == r_count - LEN_W'(1));

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_timer_clr_nxt = 1'b0;
        w_overflow_nxt  = 1'b0;
        w_wr_en         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    w_wr_en         = 1'b1;
                    w_count_nxt     = LEN_W'(1);
                    w_timer_clr_nxt = 1'b1;
                    w_state_nxt     = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // A fresh byte beats a coincident timeout; a timeout seen while
                // the restart pulse is still out is stale and ignored.
                if (rx_valid) begin
                    w_wr_en         = 1'b1;
                    w_count_nxt     = w_count_inc;
                    w_timer_clr_nxt = 1'b1;
                    if (w_count_inc == FULL_CNT) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end else if (timer_expired && !r_timer_clr) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_overflow_nxt = rx_valid;
                if (out_ready) begin
                    if (w_last) begin
                        w_state_nxt     = ST_IDLE;
                        w_count_nxt     = '0;
                        w_rd_ptr_nxt    = '0;
                        w_timer_clr_nxt = 1'b1;
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr + LEN_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_count_nxt  = '0;
                w_rd_ptr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_timer_clr <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_timer_clr <= w_timer_clr_nxt;
            r_overflow  <= w_overflow_nxt;
        end
    end

    // Hold the external timer cleared for as long as this block is in reset.
    assign timer_clr = r_timer_clr | ~reset;
    assign timer_en  = (r_state == ST_COLLECT);
    assign out_valid = (r_state == ST_DRAIN);
    assign out_data  = w_rd_data;
    assign out_last  = w_last;
    assign frame_len = (r_state == ST_DRAIN) ? r_count : '0;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_frame_collector.sv
// Directed self-checking bench for uart_rx_frame_collector (DEPTH=16).
module tb_uart_rx_frame_collector;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       timer_expired;
    logic       timer_en;
    logic       timer_clr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [4:0] frame_len;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_frame_collector #(
        .DATA_W (8),
        .DEPTH  (16),
        .LEN_W  (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .timer_expired (timer_expired),
        .timer_en      (timer_en),
        .timer_clr     (timer_clr),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .frame_len     (frame_len),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    logic [7:0] exp_bytes [3];
    logic       rdy_pat   [6];
    int         idx;

    initial begin
        reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        timer_expired = 1'b0; out_ready = 1'b0;

        // Power-on reset
        tick(); tick();
        chk("rst_timer_clr", 32'(timer_clr), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last",  32'(out_last), 0);
        chk("rst_timer_en",  32'(timer_en), 0);
        chk("rst_frame_len", 32'(frame_len), 0);
        chk("rst_overflow",  32'(overflow), 0);
        reset = 1'b1;
        tick();
        chk("post_rst_clr", 32'(timer_clr), 0);

        // Reset in the middle of a 5-byte collection
        for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i));
        chk("mid_timer_en", 32'(timer_en), 1);
        tick();
        chk("mid_clr_settled", 32'(timer_clr), 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_clr_comb", 32'(timer_clr), 1);
        tick();
        timer_expired = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_en", 32'(timer_en), 0);
        tick();
        chk("mid_rst_valid2", 32'(out_valid), 0);
        chk("mid_rst_clr2", 32'(timer_clr), 1);
        reset = 1'b1; timer_expired = 1'b0;
        tick();
        chk("mid_rel_valid", 32'(out_valid), 0);
        chk("mid_rel_clr", 32'(timer_clr), 0);
        send(8'h5A);
        chk("nf_clr_pulse", 32'(timer_clr), 1);
        tick();
        timer_expired = 1'b1;
        tick();
        timer_expired = 1'b0;
        chk("nf_valid", 32'(out_valid), 1);
        chk("nf_data", 32'(out_data), 32'h5A);
        chk("nf_len", 32'(frame_len), 1);
        chk("nf_last", 32'(out_last), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("nf_done", 32'(out_valid), 0);
        tick();

        // Three bytes closed by the idle timeout
        send(8'h11); send(8'h22); send(8'h33);
        for (int i = 0; i < 10; i++) tick();
        chk("t3_timer_en", 32'(timer_en), 1);
        chk("t3_clr_quiet", 32'(timer_clr), 0);
        chk("t3_not_closed", 32'(out_valid), 0);
        timer_expired = 1'b1;
        tick();
        timer_expired = 1'b0;
        chk("t3_valid", 32'(out_valid), 1);
        chk("t3_en_off", 32'(timer_en), 0);
        chk("t3_len", 32'(frame_len), 3);
        out_ready = 1'b1;
        chk("t3_b0", 32'(out_data), 32'h11);
        chk("t3_l0", 32'(out_last), 0);
        tick();
        chk("t3_b1", 32'(out_data), 32'h22);
        chk("t3_l1", 32'(out_last), 0);
        tick();
        chk("t3_b2", 32'(out_data), 32'h33);
        chk("t3_l2", 32'(out_last), 1);
        tick();
        out_ready = 1'b0;
        chk("t3_idle", 32'(out_valid), 0);
        chk("t3_end_clr", 32'(timer_clr), 1);
        tick();
        chk("t3_end_clr_off", 32'(timer_clr), 0);

        // Full 16-byte frame, then a 17th byte during drain
        for (int i = 0; i < 16; i++) begin
            chk("full_pre_valid", 32'(out_valid), 0);
            send(8'(i));
        end
        chk("full_valid", 32'(out_valid), 1);
        chk("full_len", 32'(frame_len), 16);
        send(8'h99);
        chk("full_ovf", 32'(overflow), 1);
        chk("full_hold", 32'(out_data), 32'h00);
        tick();
        chk("full_ovf_off", 32'(overflow), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("full_data", 32'(out_data), 32'(i));
            chk("full_last", 32'(out_last), (i == 15) ? 1 : 0);
            tick();
        end
        out_ready = 1'b0;
        chk("full_done", 32'(out_valid), 0);
        tick();

        // Byte and timeout in the same cycle, then a stalled drain
        send(8'h01); send(8'h02);
        tick();
        rx_data = 8'hAA; rx_valid = 1'b1; timer_expired = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("race_open", 32'(out_valid), 0);
        chk("race_clr", 32'(timer_clr), 1);
        chk("race_en", 32'(timer_en), 1);
        tick();
        chk("race_stale", 32'(out_valid), 0);
        tick();
        timer_expired = 1'b0;
        chk("race_close", 32'(out_valid), 1);
        chk("race_len", 32'(frame_len), 3);
        exp_bytes[0] = 8'h01; exp_bytes[1] = 8'h02; exp_bytes[2] = 8'hAA;
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0;
        rdy_pat[3] = 1'b1; rdy_pat[4] = 1'b0; rdy_pat[5] = 1'b1;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            out_ready = rdy_pat[i];
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", 32'(out_data), 32'(exp_bytes[idx]));
            chk("stall_last", 32'(out_last), (idx == 2) ? 1 : 0);
            tick();
            if (rdy_pat[i]) idx++;
        end
        out_ready = 1'b0;
        chk("stall_idle", 32'(out_valid), 0);
        chk("stall_clr", 32'(timer_clr), 1);
        chk("stall_en", 32'(timer_en), 0);
        tick();
        chk("stall_clr_once", 32'(timer_clr), 0);
        chk("stall_en_idle", 32'(timer_en), 0);
        send(8'h77);
        tick();
        timer_expired = 1'b1;
        tick();
        timer_expired = 1'b0;
        chk("one_valid", 32'(out_valid), 1);
        chk("one_len", 32'(frame_len), 1);
        chk("one_data", 32'(out_data), 32'h77);
        chk("one_last", 32'(out_last), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("one_done", 32'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_collector.md
Name: uart_rx_frame_collector

Overview:
- Downstream consumer of the 40 ms idle timer (timer_expired input is that timer's out).
- Collects bytes from the UART receiver into an internal buffer, controls the timer (enable and clear), and closes a frame on idle timeout or when the buffer is full.
- Drains the closed frame over a valid/ready byte stream with a last marker, for the command/packet layer above.

Parameters:
- DATA_W, 8, byte width.
- DEPTH, 16, maximum bytes per frame (buffer entries); at least 2.
- LEN_W, 5, width of the frame-length output; must hold DEPTH (clog2(DEPTH+1)).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- rx_data  in  DATA_W  received byte; valid only when rx_valid is high.
- rx_valid  in  1  one-cycle strobe: new byte from the UART receiver.
- timer_expired  in  1  level from the idle timer: idle period elapsed.
- timer_en  out  1  timer count enable.
- timer_clr  out  1  timer reset (active-high); restarts the idle period.
- out_data  out  DATA_W  frame byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the byte this cycle.
- out_last  out  1  high with the final byte of the frame.
- frame_len  out  LEN_W  byte count of the frame being drained.
- overflow  out  1  one-cycle pulse: a byte arrived during DRAIN and was dropped.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE, count=0, rd_ptr=0.
  - out_valid=0, out_last=0, overflow=0, frame_len=0, timer_en=0.
  - timer_clr=1 combinationally for the whole time reset is low. This keeps the timer reset while this block is in reset.
  - Reset in any state aborts the frame. Buffered bytes are discarded, and there is no partial out_last.
- States: IDLE, COLLECT, DRAIN.
- IDLE:
  - rx_valid -> buf[0]=rx_data, count=1, state -> COLLECT.
  - Registered timer_clr is high on the next cycle.
- COLLECT:
  - timer_en=1.
  - rx_valid -> buf[count]=rx_data, count+1, timer_clr pulse next cycle.
  - If the new count equals DEPTH -> DRAIN, with no wait for the timeout.
  - timer_expired is honoured only when rx_valid=0 and timer_clr=0 in that cycle. Then state -> DRAIN.
  - rx_valid and timer_expired in the same cycle: the byte wins. It is appended, the timer restarts, and the state stays COLLECT (unless the buffer is now full).
- DRAIN:
  - timer_en=0.
  - out_valid=1, out_data=buf[rd_ptr], frame_len=count, out_last=(rd_ptr==count-1).
  - Outputs are held stable while out_ready=0.
  - A handshake (out_valid & out_ready) advances rd_ptr.
  - Handshake on the last byte -> IDLE next cycle. On that cycle count=0, rd_ptr=0, out_valid=0, and timer_clr pulses for one cycle.
  - rx_valid during DRAIN: the byte is dropped and overflow pulses on the next cycle. Buffer and outputs are unaffected.
- timer_clr rules:
  - Registered; exactly one cycle per event (accepted byte or end of frame), plus forced high during reset.
  - Between events and outside reset, timer_clr is 0.
- Widths:
  - count and rd_ptr are LEN_W wide and never exceed DEPTH.
  - No wrap: writes are blocked once count==DEPTH because the state is then DRAIN.
- Latency:
  - Timeout to first out_valid: 1 cycle.
  - 16th byte strobe to out_valid: 1 cycle.
  - Back-to-back out_ready=1 gives 1 byte per cycle.
- A frame of DEPTH bytes is always at least 1 byte, so no empty frames are emitted.

Decomposition:
- Shared UART package holds:
  - the DATA_W constant;
  - the state encoding (IDLE=2'd0, COLLECT=2'd1, DRAIN=2'd2);
  - the default DEPTH.
- One natural sub-module: frame_buffer. It is a DEPTH x DATA_W register array with a write port (index=count) and a read port (index=rd_ptr).
- The FSM, counters and timer control stay in the top level.
- The timer itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset low mid-COLLECT with 5 bytes, then release -> timer_clr=1 during reset; out_valid never rises; next frame starts at buf[0].
- Send 0x11, 0x22, 0x33, then raise timer_expired 10 cycles later; out_ready=1 -> 0x11, 0x22, 0x33 on consecutive cycles; frame_len=3; out_last only on 0x33; IDLE after.
- Send 16 bytes 0x00..0x0F with no timeout -> DRAIN entered 1 cycle after the 16th strobe; 16 outputs; out_last on 0x0F; 17th byte sent during DRAIN -> overflow pulse, byte absent from the output.
- Assert rx_valid(0xAA) and timer_expired in the same cycle with 2 bytes buffered -> frame not closed; count=3; timer_clr pulses; later timeout emits 3 bytes ending 0xAA.
- DRAIN with out_ready toggling 1,0,0,1,0,1 -> out_data/out_last held during stalls; exactly one advance per handshake; no byte duplicated or lost.
- After the last handshake -> timer_clr is a single-cycle pulse; timer_en=0 in IDLE; a new byte 2 cycles later starts frame_len=1.
